// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN swaps the iterative multiply for a single-cycle 2W-bit product.
module execute_muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  flush_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] op_a_i,
   input  logic [DATA_WIDTH-1:0] op_b_i,
   input  logic [4:0]            rd_addr_i,
   output logic                  stall_o,
   output logic                  result_valid_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [4:0]            rd_addr_o
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q;
   logic [2:0]       funct3_q;
   logic [W-1:0]     opd_q;      // multiplicand (mul) or divisor (div)
   logic [W-1:0]     hi_q;       // product high half / partial remainder
   logic [W-1:0]     lo_q;       // multiplier -> product low half / dividend -> quotient
   logic             neg_q;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       tag_q;
   logic             valid_q;
   logic [W-1:0]     result_q;
   logic [4:0]       rd_q;

   logic             a_signed, b_signed, a_neg, b_neg, in_mul, in_neg;
   logic             div_zero, div_ovf;
   logic [W-1:0]     a_mag, b_mag, special_res;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      in_mul      = ~funct3_i[2];
      a_signed    = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
      b_signed    = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
      a_neg       = a_signed & op_a_i[W-1];
      b_neg       = b_signed & op_b_i[W-1];
      a_mag       = a_neg ? -op_a_i : op_a_i;
      b_mag       = b_neg ? -op_b_i : op_b_i;
      in_neg      = (funct3_i == 3'b110) ? a_neg : (a_neg ^ b_neg);
      div_zero    = funct3_i[2] && (op_b_i == '0);
      div_ovf     = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                    (op_a_i == MIN_VAL) && (op_b_i == '1);
      special_res = '0;
      if (div_zero) special_res = funct3_i[1] ? op_a_i : '1;
      else          special_res = funct3_i[1] ? '0 : MIN_VAL;
   end

   logic [W:0]     add_sum, sub_tmp, sub_diff;
   logic [W-1:0]   hi_step, lo_step;
   logic [2*W-1:0] prod_fin, prod_sgn;
   logic [W-1:0]   quo_fin, rem_fin, calc_res;
   logic           calc_last, fast_last;

   always_comb begin
      add_sum  = '0;
      sub_tmp  = '0;
      sub_diff = '0;
      hi_step  = hi_q;
      lo_step  = lo_q;
      if (!funct3_q[2]) begin
         add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
         hi_step = add_sum[W:1];
         lo_step = {add_sum[0], lo_q[W-1:1]};
      end else begin
         // Restoring step: borrow out of the W+1 bit subtract means "does not fit".
         sub_tmp  = {hi_q, lo_q[W-1]};
         sub_diff = sub_tmp - {1'b0, opd_q};
         if (!sub_diff[W]) begin
            hi_step = sub_diff[W-1:0];
            lo_step = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_step = sub_tmp[W-1:0];
            lo_step = {lo_q[W-2:0], 1'b0};
         end
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fast_prod;
   assign fast_prod = {{W{1'b0}}, opd_q} * {{W{1'b0}}, lo_q};
   assign fast_last = ~funct3_q[2];
   assign prod_fin  = fast_prod;
`else
   assign fast_last = 1'b0;
   assign prod_fin  = {hi_step, lo_step};
`endif

   always_comb begin
      prod_sgn  = neg_q ? -prod_fin : prod_fin;
      quo_fin   = neg_q ? -lo_step : lo_step;
      rem_fin   = neg_q ? -hi_step : hi_step;
      calc_last = fast_last || (cnt_q == CNT_W'(W-1));
      calc_res  = '0;
      case (funct3_q)
         3'b000:                 calc_res = prod_fin[W-1:0];
         3'b001, 3'b010, 3'b011: calc_res = prod_sgn[2*W-1:W];
         3'b100, 3'b101:         calc_res = quo_fin;
         default:                calc_res = rem_fin;
      endcase
   end

   assign stall_o        = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
   assign result_valid_o = valid_q;
   assign result_o       = result_q;
   assign rd_addr_o      = rd_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         funct3_q <= '0;
         opd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         tag_q    <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     funct3_q <= funct3_i;
                     neg_q    <= in_neg;
                     tag_q    <= rd_addr_i;
                     opd_q    <= in_mul ? a_mag : b_mag;
                     lo_q     <= in_mul ? b_mag : a_mag;
                     hi_q     <= '0;
                     cnt_q    <= '0;
                     if (div_zero || div_ovf) begin
                        state_q  <= DONE;
                        result_q <= special_res;
                        rd_q     <= rd_addr_i;
                        valid_q  <= 1'b1;
                     end else begin
                        state_q <= CALC;
                     end
                  end
               end
               CALC: begin
                  hi_q  <= hi_step;
                  lo_q  <= lo_step;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (calc_last) begin
                     state_q  <= DONE;
                     cnt_q    <= '0;
                     result_q <= calc_res;
                     rd_q     <= tag_q;
                     valid_q  <= 1'b1;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_execute_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] op_a_i = '0;
   logic [31:0] op_b_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        stall_o;
   logic        result_valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] MINV = 32'h8000_0000;

   execute_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .flush_i        (flush_i),
      .funct3_i       (funct3_i),
      .op_a_i         (op_a_i),
      .op_b_i         (op_b_i),
      .rd_addr_i      (rd_addr_i),
      .stall_o        (stall_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o),
      .rd_addr_o      (rd_addr_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain 64-bit / integer arithmetic on the RV32M definitions.
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      ua = longint'({32'b0, a});
      longint      ub = longint'({32'b0, b});
      logic [63:0] p;
      int          ia = $signed(a);
      int          ib = $signed(b);
      int          iq;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
            iq = ia / ib; return iq;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
            iq = ia % ib; return iq;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f3[2]) return 2;
`endif
      return 33;
   endfunction

   // Starts one op on the next cycle T, then checks pulse cycle, stall length, result and tag.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int lat, vk, stalls;
      logic [31:0] got;
      logic [4:0]  got_rd;
      lat = ref_latency(f3, a, b);
      vk = -1; stalls = 0; got = '0; got_rd = '0;
      @(posedge clk); #1;
      funct3_i = f3; op_a_i = a; op_b_i = b; rd_addr_i = rd; start_i = 1'b1;
      #1;
      if (stall_o) stalls++;
      for (int k = 1; k <= 60 && vk < 0; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         #1;
         if (stall_o) stalls++;
         if (result_valid_o) begin
            vk = k; got = result_o; got_rd = rd_addr_o;
         end
      end
      check({tag, " latency"}, vk, lat);
      check({tag, " stall_cycles"}, stalls, lat);
      check({tag, " result"}, got, exp);
      check({tag, " rd"}, got_rd, rd);
      @(posedge clk); #2;
      check({tag, " pulse_width"}, result_valid_o, 1'b0);
   endtask

   initial begin
      int pulses, first_k, seen;
      int pk[$];
      logic [2:0]  rf3;
      logic [31:0] ra, rb;

      // Reset state
      #12;
      check("reset valid", result_valid_o, 1'b0);
      check("reset stall", stall_o, 1'b0);
      check("reset result", result_o, 32'h0);
      check("reset rd", rd_addr_o, 5'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed cases
      run_op("DIV -7/2",     3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
      run_op("REM -7%2",     3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
      run_op("DIVU by0",     3'd5, 32'h1234_5678, 32'd0, 5'd7, 32'hFFFF_FFFF);
      run_op("REMU by0",     3'd7, 32'h1234_5678, 32'd0, 5'd8, 32'h1234_5678);
      run_op("DIV ovf",      3'd4, MINV, 32'hFFFF_FFFF, 5'd9, MINV);
      run_op("REM ovf",      3'd6, MINV, 32'hFFFF_FFFF, 5'd10, 32'h0);
      run_op("MULHU max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE);
      run_op("MULH min",     3'd1, MINV, MINV, 5'd12, 32'h4000_0000);
      run_op("MUL -1x3",     3'd0, 32'hFFFF_FFFF, 32'd3, 5'd13, 32'hFFFF_FFFD);
      run_op("MULHSU -1xmax", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFF);
      run_op("DIV by0",      3'd4, 32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFFF);

      // Flush at T+10 kills the op; restart at T+12 completes at T+45
      @(posedge clk); #1;
      funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7; rd_addr_i = 5'd3; start_i = 1'b1;
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         if (k == 10) flush_i = 1'b1;
         #1;
         if (result_valid_o) seen++;
      end
      @(posedge clk); #1;
      flush_i = 1'b0;
      #1;
      check("flush stall", stall_o, 1'b0);
      check("flush valid", result_valid_o, 1'b0);
      check("flush no_pulse", seen, 0);
      run_op("DIVU after flush", 3'd5, 32'd100, 32'd7, 5'd3, 32'd14);

      // Async reset mid-CALC at T+5
      @(posedge clk); #1;
      funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd3; rd_addr_i = 5'd21; start_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("rst stall", stall_o, 1'b0);
      check("rst valid", result_valid_o, 1'b0);
      check("rst result", result_o, 32'h0);
      check("rst rd", rd_addr_o, 5'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 45; k++) begin
         @(posedge clk); #2;
         if (result_valid_o) seen++;
      end
      check("rst no_pulse", seen, 0);

      // start_i held high: one result every 34 cycles
      @(posedge clk); #1;
      funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7; rd_addr_i = 5'd2; start_i = 1'b1;
      for (int k = 1; k <= 110; k++) begin
         @(posedge clk); #2;
         if (result_valid_o) pk.push_back(k);
      end
      pulses = pk.size();
      first_k = (pulses > 0) ? pk[0] : -1;
      check("cont pulses", pulses, 3);
      check("cont first", first_k, 33);
      if (pulses == 3) begin
         check("cont period1", pk[1] - pk[0], 34);
         check("cont period2", pk[2] - pk[1], 34);
      end
      start_i = 1'b0;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;

      // Randomized ops against the model
      for (int i = 0; i < 24; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'h0;
            1: begin ra = MINV; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 15));
            default: ;
         endcase
         run_op($sformatf("rand%0d f3=%0d", i, rf3), rf3, ra, rb, 5'($urandom_range(0, 31)),
                ref_result(rf3, ra, rb));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
RV32M multiply/divide unit in the execute stage. It consumes the operands and destination that the decode/execute pipeline register delivers, and drives the stall back toward that register. It is iterative: it holds the pipeline with stall_o while it computes, then presents a one-cycle result to the execute/memory path. Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.

Parameters:
DATA_WIDTH, 32, operand/result width; the counter is $clog2(DATA_WIDTH) bits wide.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  M-extension instruction valid in execute
flush_i  input  1  execute flush (branch mispredict/jump)
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  input  DATA_WIDTH  rs1 value (rd1E)
op_b_i  input  DATA_WIDTH  rs2 value (rd2E)
rd_addr_i  input  5  destination register
stall_o  output  1  hold fetch/decode/execute pipe registers
result_valid_o  output  1  result valid, one-cycle pulse
result_o  output  DATA_WIDTH  result
rd_addr_o  output  5  destination tag for result

Behaviour:
- Reset (async, rst_n=0): state IDLE; stall_o=0, result_valid_o=0, result_o=0, rd_addr_o=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE: if start_i=1 and flush_i=0, latch funct3, operand magnitudes, result sign and rd_addr. Next state is CALC, or DONE for a special case.
- CALC: one radix-2 step per cycle (shift-add multiply / restoring divide). The counter runs 0..DATA_WIDTH-1. At the last step the next state is DONE.
- DONE: result_valid_o=1. result_o and rd_addr_o are registered and sign-corrected. Next state is IDLE unconditionally. start_i is ignored in DONE, because the same instruction leaves execute on this edge.
- stall_o: combinational.
  - stall_o = (state==IDLE & start_i & !flush_i) | (state==CALC).
  - stall_o is 0 in DONE.
- Latency for start accepted at cycle T:
  - CALC runs T+1..T+32.
  - DONE at T+33.
  - stall_o is high T..T+32, which is 33 cycles.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Signed ops compute on magnitudes and negate the result at DONE.
  - REM sign follows the dividend. DIV quotient sign is sign(a) XOR sign(b).
- Result select:
  - MUL returns product[31:0]; MULH* return product[63:32].
  - DIV* return the quotient; REM* return the remainder.
- Special cases, resolved in IDLE (next state DONE, stall_o high only at T):
  - Divide by zero: quotient = all ones; remainder = op_a_i.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): quotient = 0x80000000; remainder = 0.
- Flush: flush_i=1 in any state forces IDLE on the next edge and result_valid_o=0 (no pulse). flush_i has priority over start_i in the same cycle.
- Reset asserted mid-CALC aborts immediately; no result pulse follows deassertion.
- result_o and rd_addr_o hold their last value outside DONE; only result_valid_o qualifies them.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational 64-bit product. CALC lasts exactly 1 cycle, so DONE is at T+2 and stall_o is high T..T+1. Divides are unchanged.
- Undefined: all ops are iterative as above, and no hardware multiplier is inferred.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2, rd=5 -> stall_o high 33 cycles; at T+33 result_valid_o=1, result_o=0xFFFFFFFD, rd_addr_o=5; REM with the same operands -> 0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> DONE at T+1, result_o=0xFFFFFFFF; REMU with the same operands -> 0x12345678.
- DIV a=0x80000000, b=0xFFFFFFFF -> DONE at T+1, result_o=0x80000000; REM with the same operands -> 0x00000000.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH a=b=0x80000000 -> 0x40000000; MUL a=0xFFFFFFFF, b=3 -> 0xFFFFFFFD; with MULDIV_FAST_MUL_EN defined, each has result_valid_o at T+2.
- Start DIVU a=100, b=7; assert flush_i at T+10 -> state IDLE at T+11, stall_o=0, no result_valid_o pulse. A new start at T+12 with a=100, b=7 yields result_o=14 at T+45.
- Start DIV, drop rst_n at T+5 for 1 cycle -> all outputs 0 immediately, no pulse afterward. Hold start_i=1 continuously -> exactly one result per 34 cycles (the DONE cycle ignores start_i).
